// File: rtl/rtc_bus_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rtc_pkg
//  Description : Shared definitions for the RTC bus sequencer: register
//                addresses, FSM state and operation encodings, and the
//                register count. Defining RTC_DATE_EN adds the date
//                registers (dia, mes, anio).
//  Revision    : 1.0 - initial release
// ============================================================================
package rtc_pkg;

    localparam logic [7:0] ADDR_CMD  = 8'hF0;
    localparam logic [7:0] ADDR_SEG  = 8'h21;
    localparam logic [7:0] ADDR_MIN  = 8'h22;
    localparam logic [7:0] ADDR_HORA = 8'h23;
`ifdef RTC_DATE_EN
    localparam logic [7:0] ADDR_DIA  = 8'h24;
    localparam logic [7:0] ADDR_MES  = 8'h25;
    localparam logic [7:0] ADDR_ANIO = 8'h26;
    localparam int         NUM_REGS  = 6;
`else
    localparam int         NUM_REGS  = 3;
`endif

    // Frame index width: a read burst needs NUM_REGS+1 frames (cmd + regs).
    localparam int IDX_W = 3;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } op_t;

endpackage
`default_nettype wire

// File: rtl/rtc_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : rtc_bus_sequencer_if
//  Description : Handshake between the sequencer and the RTC bus timing
//                generator.
//                En_Esc/En_Lect : frame enables (sequencer -> generator)
//                dato_out       : byte toward the tri-state driver
//                DIR1/DAT1      : address / data windows (generator)
//                DAT_LECT       : read capture window (generator)
//                cambio_est2    : end-of-frame pulse (generator)
//                dato_in        : byte sampled from the RTC bus
//  Revision    : 1.0 - initial release
// ============================================================================
interface rtc_bus_sequencer_if;
    logic       En_Esc;
    logic       En_Lect;
    logic [7:0] dato_out;
    logic       DIR1;
    logic       DAT1;
    logic       DAT_LECT;
    logic       cambio_est2;
    logic [7:0] dato_in;

    modport master (
        output En_Esc, En_Lect, dato_out,
        input  DIR1, DAT1, DAT_LECT, cambio_est2, dato_in
    );

    modport slave (
        input  En_Esc, En_Lect, dato_out,
        output DIR1, DAT1, DAT_LECT, cambio_est2, dato_in
    );
endinterface
`default_nettype wire

// File: rtl/rtc_bus_sequencer_addr_table.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_addr_table
//  Description : Maps the current frame index and operation to the RTC
//                address, a command-frame flag and the register slot.
//                Read bursts begin with the command frame (idx 0), so their
//                register slot is idx-1. RTC_DATE_EN adds the date slots.
//  Ports       : idx, is_rd (in); addr, is_cmd, reg_sel (out)
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_addr_table
    import rtc_pkg::*;
(
    input  wire [IDX_W-1:0] idx,
    input  wire             is_rd,
    output logic [7:0]      addr,
    output logic            is_cmd,
    output logic [IDX_W-1:0] reg_sel
);

    always_comb begin
        is_cmd  = is_rd && (idx == '0);
        reg_sel = is_rd ? (idx - IDX_W'(1)) : idx;
        if (is_cmd) begin
            reg_sel = '0;
        end
        addr = ADDR_SEG;
        if (is_cmd) begin
            addr = ADDR_CMD;
        end else begin
            case (reg_sel)
                IDX_W'(0): addr = ADDR_SEG;
                IDX_W'(1): addr = ADDR_MIN;
                IDX_W'(2): addr = ADDR_HORA;
`ifdef RTC_DATE_EN
                IDX_W'(3): addr = ADDR_DIA;
                IDX_W'(4): addr = ADDR_MES;
                IDX_W'(5): addr = ADDR_ANIO;
`endif
                default:   addr = ADDR_SEG;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_sequencer
//  Description : Walks the RTC register list, raising En_Esc/En_Lect for one
//                generator frame per register. Drives address/data onto
//                dato_out during DIR1/DAT1 and captures read bytes during
//                DAT_LECT. Write = seg,min,hora; read = cmd,seg,min,hora.
//                Macro RTC_DATE_EN adds dia,mes,anio to both sequences.
//  Ports       : clk, reset (async, active-high)
//                start_wr/start_rd : 1-cycle start pulses
//                wr_* (in) / rd_* (out, registered) : BCD values
//                busy, done : status ; bus : generator handshake (master)
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_sequencer
    import rtc_pkg::*;
#(
    parameter int GAP_CYCLES = 4
) (
    input  wire        clk,
    input  wire        reset,
    input  wire        start_wr,
    input  wire        start_rd,
    input  wire [7:0]  wr_seg,
    input  wire [7:0]  wr_min,
    input  wire [7:0]  wr_hora,
`ifdef RTC_DATE_EN
    input  wire [7:0]  wr_dia,
    input  wire [7:0]  wr_mes,
    input  wire [7:0]  wr_anio,
    output wire [7:0]  rd_dia,
    output wire [7:0]  rd_mes,
    output wire [7:0]  rd_anio,
`endif
    output wire [7:0]  rd_seg,
    output wire [7:0]  rd_min,
    output wire [7:0]  rd_hora,
    output wire        busy,
    output wire        done,
    rtc_bus_sequencer_if.master bus
);

    // At least two idle cycles so the generator frame counter can clear.
    localparam int                GAP_N    = (GAP_CYCLES < 2) ? 2 : GAP_CYCLES;
    localparam int                GAP_W    = $clog2(GAP_N);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_N - 1);

    state_t              r_state;
    op_t                 r_op;
    logic [IDX_W-1:0]    r_idx;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_en_esc;
    logic                r_en_lect;
    logic [7:0]          r_dato_out;
    logic [7:0]          r_shadow [DEPTH];
    logic [7:0]          r_rd     [DEPTH];

    logic [7:0]          w_wr     [DEPTH];
    logic [7:0]          w_addr;
    logic                w_is_cmd;
    logic [IDX_W-1:0]    w_reg_sel;
    logic [7:0]          w_wdata;
    logic [IDX_W-1:0]    w_last_idx;

    rtc_addr_table u_addr_table (
        .idx     (r_idx),
        .is_rd   (r_op == OP_RD),
        .addr    (w_addr),
        .is_cmd  (w_is_cmd),
        .reg_sel (w_reg_sel)
    );

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wr[i] = 8'h00;
        end
        w_wr[0] = wr_seg;
        w_wr[1] = wr_min;
        w_wr[2] = wr_hora;
`ifdef RTC_DATE_EN
        w_wr[3] = wr_dia;
        w_wr[4] = wr_mes;
        w_wr[5] = wr_anio;
`endif
    end

    // The command frame of a read burst always writes 8'h00.
    assign w_wdata    = w_is_cmd ? 8'h00 : r_shadow[w_reg_sel];
    assign w_last_idx = (r_op == OP_RD) ? IDX_W'(NUM_REGS) : IDX_W'(NUM_REGS - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_WR;
            r_idx      <= '0;
            r_gap_cnt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_en_esc   <= 1'b0;
            r_en_lect  <= 1'b0;
            r_dato_out <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                r_shadow[i] <= 8'h00;
                r_rd[i]     <= 8'h00;
            end
        end else begin
            // DIR1 has priority should the generator ever overlap the windows.
            if (r_state == ST_FRAME && bus.DIR1) begin
                r_dato_out <= w_addr;
            end else if (r_state == ST_FRAME && bus.DAT1) begin
                r_dato_out <= w_wdata;
            end else begin
                r_dato_out <= 8'h00;
            end

            // Every DAT_LECT cycle overwrites, so the last sample wins.
            if (r_state == ST_FRAME && r_en_lect && bus.DAT_LECT) begin
                r_rd[w_reg_sel] <= bus.dato_in;
            end

            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start_wr) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            r_shadow[i] <= w_wr[i];
                        end
                        r_op     <= OP_WR;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        r_en_esc <= 1'b1;
                        r_state  <= ST_FRAME;
                    end else if (start_rd) begin
                        // Frame 0 of a read is the command write.
                        r_op     <= OP_RD;
                        r_idx    <= '0;
                        r_busy   <= 1'b1;
                        r_en_esc <= 1'b1;
                        r_state  <= ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    if (bus.cambio_est2) begin
                        r_en_esc  <= 1'b0;
                        r_en_lect <= 1'b0;
                        r_gap_cnt <= '0;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        if (r_idx != w_last_idx) begin
                            // Frames after the first are never command frames.
                            r_idx     <= r_idx + IDX_W'(1);
                            r_en_esc  <= (r_op == OP_WR);
                            r_en_lect <= (r_op == OP_RD);
                            r_state   <= ST_FRAME;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.En_Esc   = r_en_esc;
    assign bus.En_Lect  = r_en_lect;
    assign bus.dato_out = r_dato_out;
    assign busy         = r_busy;
    assign done         = r_done;
    assign rd_seg       = r_rd[0];
    assign rd_min       = r_rd[1];
    assign rd_hora      = r_rd[2];
`ifdef RTC_DATE_EN
    assign rd_dia       = r_rd[3];
    assign rd_mes       = r_rd[4];
    assign rd_anio      = r_rd[5];
`endif

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtc_bus_sequencer
//  Description : Self-checking bench for rtc_bus_sequencer. A timing
//                generator + RTC register-file model answers the frames;
//                expected frame lists and read results come from a
//                register-level model of the RTC contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_sequencer;
    import rtc_pkg::*;

    localparam int GAP = 4;
    localparam int NR  = NUM_REGS;

    logic clk = 1'b0;
    logic reset;
    logic start_wr;
    logic start_rd;
    logic [7:0] wr_v [6];
    wire  [7:0] rd_seg, rd_min, rd_hora;
`ifdef RTC_DATE_EN
    wire  [7:0] rd_dia, rd_mes, rd_anio;
`endif
    wire        busy;
    wire        done;

    always #5 clk = ~clk;

    rtc_bus_sequencer_if bus_if ();

    rtc_bus_sequencer #(.GAP_CYCLES(GAP)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_wr (start_wr),
        .start_rd (start_rd),
        .wr_seg   (wr_v[0]),
        .wr_min   (wr_v[1]),
        .wr_hora  (wr_v[2]),
`ifdef RTC_DATE_EN
        .wr_dia   (wr_v[3]),
        .wr_mes   (wr_v[4]),
        .wr_anio  (wr_v[5]),
        .rd_dia   (rd_dia),
        .rd_mes   (rd_mes),
        .rd_anio  (rd_anio),
`endif
        .rd_seg   (rd_seg),
        .rd_min   (rd_min),
        .rd_hora  (rd_hora),
        .busy     (busy),
        .done     (done),
        .bus      (bus_if)
    );

    typedef struct {
        bit         is_rd;
        logic [7:0] addr;
        logic [7:0] data;
    } frame_t;

    typedef struct {
        bit               wp;
        bit               rp;
        bit               mid_rd;
        bit               mid_wr;
        bit               preload;
        logic [5:0][7:0]  pre;
        logic [5:0][7:0]  wv;
        int               exp_nf;
        logic [5:0][7:0]  exp_rd;
    } vec_t;

    logic [7:0] reg_addr [6] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    logic [7:0] rtc_mem  [256];
    logic [7:0] exp_regs [6];
    logic [7:0] exp_rd_m [6];
    frame_t     flog [$];
    frame_t     efr  [$];
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rd_now(input int i);
        case (i)
            0: return rd_seg;
            1: return rd_min;
            2: return rd_hora;
`ifdef RTC_DATE_EN
            3: return rd_dia;
            4: return rd_mes;
            5: return rd_anio;
`endif
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] rbcd(input int maxv);
        int v;
        v = int'($urandom_range(0, maxv));
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Timing generator + RTC register file. Frame layout (k = cycle in frame):
    // DIR1 k2-3, DAT1 (write) or DAT_LECT k6-7, cambio_est2 at k9.
    initial begin : g_generator
        int  k;
        int  gap_run;
        bit  cur_rd;
        bit  overlap;
        logic [7:0] cur_addr;
        logic [7:0] d;
        k = 0; gap_run = 0; cur_rd = 0; overlap = 0; cur_addr = 8'h00;
        bus_if.DIR1 = 0; bus_if.DAT1 = 0; bus_if.DAT_LECT = 0;
        bus_if.cambio_est2 = 0; bus_if.dato_in = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                k = 0; gap_run = 0;
                bus_if.DIR1 = 0; bus_if.DAT1 = 0; bus_if.DAT_LECT = 0;
                bus_if.cambio_est2 = 0;
            end else if (!(bus_if.En_Esc || bus_if.En_Lect)) begin
                k = 0;
                gap_run++;
                bus_if.DIR1 = 0; bus_if.DAT1 = 0; bus_if.DAT_LECT = 0;
                // Stray end-of-frame pulses outside a frame must be ignored.
                bus_if.cambio_est2 = ($urandom_range(0, 5) == 0);
            end else begin
                k++;
                if (k == 1) begin
                    chk("one_enable", 32'(bus_if.En_Esc & bus_if.En_Lect), 0);
                    if (flog.size() > 0) chk("gap_len", 32'(gap_run >= GAP), 1);
                    cur_rd  = bus_if.En_Lect;
                    overlap = $urandom_range(0, 1) != 0;
                end
                gap_run = 0;
                if (k == 4) cur_addr = bus_if.dato_out;
                if (k == 5) chk("dato_idle", 32'(bus_if.dato_out), 0);
                if (k == 8) begin
                    if (cur_rd) begin
                        d = rtc_mem[cur_addr];
                    end else begin
                        d = bus_if.dato_out;
                        rtc_mem[cur_addr] = d;
                    end
                    flog.push_back('{cur_rd, cur_addr, d});
                end
                bus_if.DIR1        = (k == 2 || k == 3);
                bus_if.DAT1        = !cur_rd && (k == 6 || k == 7 || (overlap && k == 3));
                bus_if.DAT_LECT    = (k == 6 || k == 7);
                bus_if.dato_in     = (cur_rd && k == 7) ? rtc_mem[cur_addr] : 8'($urandom);
                bus_if.cambio_est2 = (k == 9);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            chk("busy_at_done", 32'(busy), 1);
        end
    end

    task automatic run_txn(input bit wp, input bit rp, input bit mid_rd, input bit mid_wr,
                           input logic [5:0][7:0] wv, input bit use_tbl, input int exp_nf,
                           input logic [5:0][7:0] exp_rd);
        int n;
        for (int i = 0; i < 6; i++) wr_v[i] = wv[i];
        efr.delete();
        if (wp) begin
            for (int i = 0; i < NR; i++) begin
                efr.push_back('{1'b0, reg_addr[i], wv[i]});
                exp_regs[i] = wv[i];
            end
        end else if (rp) begin
            efr.push_back('{1'b0, 8'hF0, 8'h00});
            for (int i = 0; i < NR; i++) begin
                efr.push_back('{1'b1, reg_addr[i], exp_regs[i]});
                exp_rd_m[i] = exp_regs[i];
            end
        end
        flog.delete();
        done_cnt = 0;
        @(negedge clk); start_wr = wp; start_rd = rp;
        @(negedge clk); start_wr = 0;  start_rd = 0;
        for (int i = 0; i < 6; i++) wr_v[i] = 8'($urandom);
        repeat (15) @(negedge clk);
        start_rd = mid_rd; start_wr = mid_wr;
        @(negedge clk); start_rd = 0; start_wr = 0;
        n = 0;
        while (done_cnt == 0 && n < 3000 && (wp || rp)) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(n < 3000), 1);
        repeat (20) @(negedge clk);
        chk("done_count", done_cnt, (wp || rp) ? 1 : 0);
        chk("busy_after", 32'(busy), 0);
        chk("num_frames", flog.size(), efr.size());
        for (int i = 0; i < efr.size(); i++) begin
            if (i < flog.size()) begin
                chk($sformatf("frame%0d_rd", i),   32'(flog[i].is_rd), 32'(efr[i].is_rd));
                chk($sformatf("frame%0d_addr", i), 32'(flog[i].addr),  32'(efr[i].addr));
                chk($sformatf("frame%0d_data", i), 32'(flog[i].data),  32'(efr[i].data));
            end
        end
        for (int i = 0; i < NR; i++) chk($sformatf("rd_model%0d", i), 32'(rd_now(i)), 32'(exp_rd_m[i]));
        if (use_tbl) begin
            chk("tbl_frames", flog.size(), exp_nf);
            for (int i = 0; i < NR; i++) chk($sformatf("tbl_rd%0d", i), 32'(rd_now(i)), 32'(exp_rd[i]));
        end
    endtask

    initial begin : g_main
        vec_t tbl [5];
        int   n;
        int   kind;
        logic [5:0][7:0] wv;

        // {anio, mes, dia, hora, min, seg}
        tbl[0] = '{1, 0, 0, 0, 0, 48'h0, {8'h00, 8'h01, 8'h01, 8'h12, 8'h34, 8'h56}, NR, 48'h0};
        tbl[1] = '{0, 1, 0, 0, 1, {8'h99, 8'h12, 8'h31, 8'h09, 8'h30, 8'h45}, 48'h0, NR + 1,
                   {8'h99, 8'h12, 8'h31, 8'h09, 8'h30, 8'h45}};
        tbl[2] = '{1, 0, 1, 0, 0, 48'h0, {8'h10, 8'h02, 8'h03, 8'h23, 8'h22, 8'h11}, NR,
                   {8'h99, 8'h12, 8'h31, 8'h09, 8'h30, 8'h45}};
        tbl[3] = '{1, 1, 0, 1, 0, 48'h0, {8'h25, 8'h07, 8'h15, 8'h23, 8'h59, 8'h00}, NR,
                   {8'h99, 8'h12, 8'h31, 8'h09, 8'h30, 8'h45}};
        tbl[4] = '{0, 1, 0, 0, 0, 48'h0, 48'h0, NR + 1,
                   {8'h25, 8'h07, 8'h15, 8'h23, 8'h59, 8'h00}};

        for (int i = 0; i < 256; i++) rtc_mem[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            exp_regs[i] = 8'h00; exp_rd_m[i] = 8'h00; wr_v[i] = 8'h00;
        end
        reset = 1; start_wr = 0; start_rd = 0;
        repeat (3) @(negedge clk);
        chk("rst_en_esc", 32'(bus_if.En_Esc), 0);
        chk("rst_en_lect", 32'(bus_if.En_Lect), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_dato_out", 32'(bus_if.dato_out), 0);
        for (int i = 0; i < NR; i++) chk($sformatf("rst_rd%0d", i), 32'(rd_now(i)), 0);
        reset = 0;
        repeat (3) @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            if (tbl[t].preload) begin
                for (int i = 0; i < NR; i++) begin
                    rtc_mem[reg_addr[i]] = tbl[t].pre[i];
                    exp_regs[i]          = tbl[t].pre[i];
                end
            end
            run_txn(tbl[t].wp, tbl[t].rp, tbl[t].mid_rd, tbl[t].mid_wr, tbl[t].wv,
                    1'b1, tbl[t].exp_nf, tbl[t].exp_rd);
        end

        // Reset in the middle of the second frame of a read burst.
        rtc_mem[reg_addr[0]] = 8'h45; exp_regs[0] = 8'h45;
        flog.delete(); done_cnt = 0;
        @(negedge clk); start_rd = 1;
        @(negedge clk); start_rd = 0;
        n = 0;
        while (flog.size() < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reach", 32'(n < 500), 1);
        reset = 1;
        @(negedge clk);
        chk("mid_en_esc", 32'(bus_if.En_Esc), 0);
        chk("mid_en_lect", 32'(bus_if.En_Lect), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_done", 32'(done), 0);
        for (int i = 0; i < NR; i++) chk($sformatf("mid_rd%0d", i), 32'(rd_now(i)), 0);
        for (int i = 0; i < 6; i++) exp_rd_m[i] = 8'h00;
        reset = 0;
        repeat (10) @(negedge clk);
        chk("mid_no_done", done_cnt, 0);
        run_txn(0, 1, 0, 0, 48'h0, 1'b0, 0, 48'h0);

        // Randomized traffic against the register model.
        for (int t = 0; t < 10; t++) begin
            kind = int'($urandom_range(0, 2));
            wv = {rbcd(99), rbcd(12), rbcd(31), rbcd(23), rbcd(59), rbcd(59)};
            run_txn(kind != 1, kind != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                    wv, 1'b0, 0, 48'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : g_watchdog
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
